// File: rtl/sensor_display_scheduler.sv
// sensor_display_scheduler
//   Time-shares the seven-segment display between N_SRC sensor sources.
//   Auto mode rotates round-robin every DWELL_CYCLES, skipping sources whose
//   valid flag is low. Manual mode pins the source picked by manual_sel.
//   hold freezes both the display word and the rotation.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   src_valid / src_value    : per-source valid flag and packed values
//   auto_en, manual_sel      : rotation enable and manual source index
//   hold                     : freeze display and rotation
//   number, dots             : registered word and decimal points for the display
//   cur_src, cur_onehot      : source currently shown (binary and one-hot)
//   switch_pulse             : one-cycle strobe on the cycle cur_src changes
module sensor_display_scheduler #(
  parameter int N_SRC        = 4,
  parameter int W_VALUE      = 16,
  parameter int W_NUMBER     = 32,
  parameter int DWELL_CYCLES = 27000000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [N_SRC-1:0]             src_valid,
  input  logic [N_SRC*W_VALUE-1:0]     src_value,
  input  logic                         auto_en,
  input  logic [$clog2(N_SRC)-1:0]     manual_sel,
  input  logic                         hold,
  output logic [W_NUMBER-1:0]          number,
  output logic [7:0]                   dots,
  output logic [$clog2(N_SRC)-1:0]     cur_src,
  output logic [N_SRC-1:0]             cur_onehot,
  output logic                         switch_pulse
);

  localparam int SEL_W = $clog2(N_SRC);
  localparam int TMR_W = $clog2(DWELL_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_FROZEN} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    cur_q, cur_d;
  logic [N_SRC-1:0]    onehot_q, onehot_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [W_NUMBER-1:0] number_q, number_d;
  logic [7:0]          dots_q, dots_d;
  logic                switch_q, switch_d;
  int                  lo_idx, nx_idx;

  // Lowest-numbered valid source, or -1 when none is valid.
  function automatic int lowest_valid(input logic [N_SRC-1:0] v);
    int r = -1;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  // First valid source after cur in wrap-around order; cur itself is tried
  // last so a lone valid source keeps the display. -1 when none is valid.
  function automatic int next_valid(input logic [N_SRC-1:0] v, input int cur);
    int r = -1;
    for (int k = N_SRC; k >= 1; k--) begin
      if (v[(cur + k) % N_SRC]) r = (cur + k) % N_SRC;
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    timer_d  = timer_q;
    number_d = number_q;
    dots_d   = dots_q;
    switch_d = 1'b0;
    onehot_d = '0;
    lo_idx   = lowest_valid(src_valid);
    nx_idx   = next_valid(src_valid, int'(cur_q));

    if (hold) begin
      state_d = S_FROZEN;
    end else begin
      // Source selection
      if (!auto_en) begin
        state_d = S_SHOW;
        timer_d = '0;
        cur_d   = (int'(manual_sel) < N_SRC) ? manual_sel : '0;
      end else if (state_q == S_IDLE) begin
        timer_d = '0;
        if (lo_idx >= 0) begin
          state_d = S_SHOW;
          cur_d   = SEL_W'(lo_idx);
        end
      end else if (state_q == S_FROZEN && src_valid == '0) begin
        state_d = S_IDLE;
        timer_d = '0;
      end else begin
        // SHOW, or leaving FROZEN with the frozen dwell count intact
        state_d = S_SHOW;
        if (timer_q == TMR_W'(DWELL_CYCLES - 1)) begin
          timer_d = '0;
          if (nx_idx < 0) state_d = S_IDLE;
          else            cur_d   = SEL_W'(nx_idx);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      // Display word for the source registered last cycle
      if (state_q == S_IDLE) begin
        number_d = '0;
        dots_d   = '0;
      end else if (src_valid[cur_q]) begin
        number_d = '0;
        number_d[W_VALUE-1:0]    = src_value[int'(cur_q)*W_VALUE +: W_VALUE];
        number_d[W_NUMBER-1 -: 4] = 4'(cur_q);
        dots_d   = '0;
      end else begin
        // Stale: keep the last shown value and flag it with the leftmost dot
        dots_d   = 8'h80;
      end

      switch_d = (cur_d != cur_q);
    end

    onehot_d[cur_d] = 1'b1;
  end

  // Register stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      onehot_q <= N_SRC'(1);
      timer_q  <= '0;
      number_q <= '0;
      dots_q   <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      onehot_q <= onehot_d;
      timer_q  <= timer_d;
      number_q <= number_d;
      dots_q   <= dots_d;
      switch_q <= switch_d;
    end
  end

  assign number       = number_q;
  assign dots         = dots_q;
  assign cur_src      = cur_q;
  assign cur_onehot   = onehot_q;
  assign switch_pulse = switch_q;

endmodule

// File: tb/tb_sensor_display_scheduler.sv
module tb_sensor_display_scheduler;

  localparam int N  = 4;
  localparam int DW = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_valid;
  logic [63:0] src_value;
  logic        auto_en;
  logic [1:0]  manual_sel;
  logic        hold;
  logic [31:0] number;
  logic [7:0]  dots;
  logic [1:0]  cur_src;
  logic [3:0]  cur_onehot;
  logic        switch_pulse;

  int checks = 0;
  int errors = 0;

  localparam logic [46:0] RST_VEC = {32'h0, 8'h0, 2'd0, 4'b0001, 1'b0};
  logic [46:0] act;
  assign act = {number, dots, cur_src, cur_onehot, switch_pulse};

  sensor_display_scheduler #(
    .N_SRC(N), .W_VALUE(16), .W_NUMBER(32), .DWELL_CYCLES(DW)
  ) dut (
    .clock(clk), .reset_n(rst_n), .src_valid(src_valid), .src_value(src_value),
    .auto_en(auto_en), .manual_sel(manual_sel), .hold(hold),
    .number(number), .dots(dots), .cur_src(cur_src), .cur_onehot(cur_onehot),
    .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: source shown, whether idle/frozen, edges left in dwell
  int          m_cur;
  bit          m_idle, m_frozen, m_pulse;
  int          m_left;
  logic [31:0] m_number;
  logic [7:0]  m_dots;

  task automatic model_reset();
    m_cur = 0; m_idle = 1; m_frozen = 0; m_left = DW;
    m_number = 0; m_dots = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    int nc;
    if (hold) begin
      m_frozen = 1; m_idle = 0; m_pulse = 0;
      return;
    end
    if (m_idle) begin
      m_number = 0; m_dots = 0;
    end else if (src_valid[m_cur]) begin
      m_number = {4'(m_cur), 12'h000, src_value[m_cur*16 +: 16]};
      m_dots = 0;
    end else begin
      m_dots = 8'h80;
    end
    nc = m_cur;
    if (!auto_en) begin
      nc = int'(manual_sel); m_left = DW; m_idle = 0;
    end else if (m_idle) begin
      m_left = DW;
      if (src_valid != 0) begin
        for (int k = N - 1; k >= 0; k--) if (src_valid[k]) nc = k;
        m_idle = 0;
      end
    end else if (m_frozen && src_valid == 0) begin
      m_idle = 1; m_left = DW;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_left = DW;
        if (src_valid == 0) m_idle = 1;
        else for (int k = N; k >= 1; k--) if (src_valid[(m_cur + k) % N]) nc = (m_cur + k) % N;
      end
    end
    m_frozen = 0;
    m_pulse = (nc != m_cur);
    m_cur = nc;
  endtask

  function automatic logic [46:0] exp_vec();
    logic [3:0] oh = '0;
    oh[m_cur] = 1'b1;
    return {m_number, m_dots, 2'(m_cur), oh, m_pulse};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_valid = '0; src_value = '0; auto_en = 1'b1;
    manual_sel = '0; hold = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act !== RST_VEC) begin errors++; $display("FAIL reset act %h exp %h", act, RST_VEC); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++;
    if (act !== exp_vec()) begin errors++; $display("FAIL reset_idle act %h exp %h", act, exp_vec()); end
  endtask

  task automatic test_rotation();
    int q[$];
    bit saw22 = 0;
    src_value = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    src_valid = 4'b1111; auto_en = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL rotation cyc %0d act %h exp %h", i, act, exp_vec()); end
      if (switch_pulse) q.push_back(int'(cur_src));
      if (cur_src == 2'd1 && number == 32'h1000_0022) saw22 = 1;
    end
    checks++;
    if (q.size() != 4) begin
      errors++; $display("FAIL rotation_pulses act %0d exp 4", q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q[i] != (i + 1) % 4) begin errors++; $display("FAIL rotation_order idx %0d act %0d exp %0d", i, q[i], (i + 1) % 4); end
      end
    end
    checks++;
    if (!saw22) begin errors++; $display("FAIL rotation_word act missing exp 10000022"); end
  endtask

  task automatic test_skip();
    int q[$];
    src_valid = 4'b1010;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL skip cyc %0d act %h exp %h", i, act, exp_vec()); end
      if (switch_pulse) q.push_back(int'(cur_src));
    end
    checks++;
    if (q.size() < 3) begin
      errors++; $display("FAIL skip_pulses act %0d exp >=3", q.size());
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        checks++;
        if (q[i] != ((i % 2 == 0) ? 1 : 3)) begin errors++; $display("FAIL skip_order idx %0d act %0d exp %0d", i, q[i], (i % 2 == 0) ? 1 : 3); end
      end
    end
    src_valid = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL skip_idle cyc %0d act %h exp %h", i, act, exp_vec()); end
    end
    checks++;
    if (number !== 32'h0 || dots !== 8'h0) begin errors++; $display("FAIL idle_word act %h/%h exp 0/0", number, dots); end
  endtask

  task automatic test_stale();
    bit found = 0;
    src_value[47:32] = 16'h0ABC;
    src_valid = 4'b1111;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL stale_seek cyc %0d act %h exp %h", i, act, exp_vec()); end
      if (switch_pulse && cur_src == 2'd2) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stale_reach act timeout exp src2"); return; end
    tick();
    src_valid = 4'b1011;
    tick();
    checks++;
    if (number !== 32'h2000_0ABC || dots !== 8'h80) begin
      errors++; $display("FAIL stale_flag act %h/%h exp 20000abc/80", number, dots);
    end
    checks++;
    if (act !== exp_vec()) begin errors++; $display("FAIL stale_model act %h exp %h", act, exp_vec()); end
    src_valid = 4'b1111;
    tick();
    checks++;
    if (dots !== 8'h00) begin errors++; $display("FAIL stale_clear act %h exp 00", dots); end
  endtask

  task automatic test_manual();
    int pulses = 0;
    auto_en = 1'b0; manual_sel = 2'd3; src_valid = 4'b0111;
    tick();
    checks++;
    if (cur_src !== 2'd3 || switch_pulse !== 1'b1) begin
      errors++; $display("FAIL manual_sel act %0d/%b exp 3/1", cur_src, switch_pulse);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL manual cyc %0d act %h exp %h", i, act, exp_vec()); end
      pulses += int'(switch_pulse);
    end
    checks++;
    if (pulses != 0 || dots !== 8'h80) begin errors++; $display("FAIL manual_steady act %0d/%h exp 0/80", pulses, dots); end
  endtask

  task automatic test_hold();
    bit found = 0;
    int n = 0;
    logic [46:0] snap;
    auto_en = 1'b1; src_valid = 4'b1111;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (switch_pulse && cur_src == 2'd0) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL hold_reach act timeout exp src0"); return; end
    repeat (5) tick();
    snap = act;
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (act !== snap || act !== exp_vec()) begin errors++; $display("FAIL hold cyc %0d act %h exp %h", i, act, snap); end
      manual_sel = 2'($urandom_range(0, 3));
      src_value = {$urandom, $urandom};
      auto_en = 1'($urandom);
    end
    hold = 1'b0; auto_en = 1'b1;
    found = 0;
    while (!found && n < 20) begin
      tick();
      n++;
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL hold_release cyc %0d act %h exp %h", n, act, exp_vec()); end
      if (switch_pulse) found = 1;
    end
    checks++;
    if (n != 5 || cur_src !== 2'd1) begin errors++; $display("FAIL hold_resume act %0d/%0d exp 5/1", n, cur_src); end
  endtask

  task automatic test_async_reset();
    auto_en = 1'b1; src_valid = 4'b1111;
    repeat (3) tick();
    @(posedge clk); model_step();
    #3; rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act !== RST_VEC) begin errors++; $display("FAIL async_reset act %h exp %h", act, RST_VEC); end
    src_valid = 4'b0100;
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++;
    if (cur_src !== 2'd2 || switch_pulse !== 1'b1 || cur_onehot !== 4'b0100) begin
      errors++; $display("FAIL reset_first act %0d/%b/%b exp 2/1/0100", cur_src, switch_pulse, cur_onehot);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
      manual_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) src_valid = 4'($urandom);
      src_value = {$urandom, $urandom};
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL random cyc %0d act %h exp %h", i, act, exp_vec()); end
    end
    hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_skip();
    test_stale();
    test_manual();
    test_hold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sensor_display_scheduler.md
Name: sensor_display_scheduler

Overview:
Time-shares the TM1638 seven-segment display between up to N_SRC sensor sources (ultrasonic distance, rotary encoder, derived values). In auto mode it rotates round-robin with a fixed dwell time and skips sources that are not valid. In manual mode it pins the source chosen by a selector. It registers a display word for seven_segment_display and sits between the sensor blocks and the display driver in hackathon_top.

Parameters:
N_SRC, 4, number of requesting sources (2..8)
W_VALUE, 16, width of each source value; W_VALUE <= W_NUMBER-4
W_NUMBER, 32, width of the number word to seven_segment_display
DWELL_CYCLES, 27000000, cycles each source is shown in auto mode (1 s at 27 MHz); must be >= 2

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
src_valid  in  N_SRC  per-source "value is meaningful" flag
src_value  in  N_SRC*W_VALUE  packed values; source i at [i*W_VALUE +: W_VALUE]
auto_en  in  1  1 = round-robin rotation, 0 = manual selection
manual_sel  in  $clog2(N_SRC)  source index used when auto_en=0
hold  in  1  freeze the display and the rotation
number  out  W_NUMBER  word to the display driver
dots  out  8  decimal points to the display driver
cur_src  out  $clog2(N_SRC)  index currently shown
cur_onehot  out  N_SRC  one-hot of cur_src, drives the TM1638 LEDs
switch_pulse  out  1  one-cycle strobe when cur_src changes

Behaviour:
- Interface: one clock (clock); reset_n is asynchronous, active-low. All outputs are registered.
- Reset values: number=0, dots=0, cur_src=0, cur_onehot=1, switch_pulse=0, dwell timer=0, state=IDLE.
- States:
  - IDLE: no source is displayed.
  - SHOW: display the current source and count the dwell.
  - FROZEN: hold is asserted.
- IDLE (auto):
  - Stay while src_valid==0. number=0, dots=0.
  - When any bit of src_valid is set, go to SHOW on the lowest valid index and raise switch_pulse if that index differs from the previous cur_src.
- SHOW (auto):
  - Dwell timer increments every cycle.
  - At timer==DWELL_CYCLES-1, pick the next valid index searching cur_src+1, cur_src+2, ... with wrap modulo N_SRC. Load cur_src the next cycle and clear the timer.
  - If the only valid source is cur_src, keep it, clear the timer, no switch_pulse.
  - If no source is valid, go to IDLE and clear the timer.
- Manual (auto_en=0, any state except FROZEN):
  - Timer is held at 0.
  - cur_src <= manual_sel one cycle after it is applied, whether or not that source is valid.
  - Never enters IDLE; a current IDLE state moves to SHOW.
- FROZEN:
  - Entered whenever hold=1, from any state.
  - cur_src, number, dots and the timer are all frozen; manual_sel and auto_en changes are ignored.
  - On hold release, return to SHOW (or IDLE if auto and nothing is valid). The timer resumes from its frozen count.
- Priority: reset_n > hold > auto/manual selection > dwell expiry.
- auto_en rising: rotation starts from the current cur_src with the timer at 0.
- auto_en falling mid-dwell: manual takes effect the next cycle.
- Display word (SHOW, not frozen): registered one cycle after the source is sampled.
  - number[W_VALUE-1:0] = src_value[cur_src]
  - number[W_NUMBER-1 -: 4] = cur_src, zero-extended; the leftmost digit shows the source id
  - All other bits 0.
- Stale flag:
  - If src_valid[cur_src]=0 while in SHOW, number keeps its last value and dots[7]=1.
  - dots[7]=0 otherwise. dots[6:0] are always 0.
- switch_pulse is high for exactly one cycle, the cycle cur_src takes its new value; cur_onehot updates the same cycle.
- Reset mid-dwell: all state returns to reset values asynchronously. First update is on the first clock edge after reset_n rises.
- Out-of-range manual_sel (>= N_SRC, when N_SRC is not a power of 2): treated as 0.

Test Plan:
1. Auto rotation: DWELL_CYCLES=10, auto_en=1, src_valid=4'b1111, values 16'h0011/0022/0033/0044 -> cur_src steps 0,1,2,3,0 every 10 cycles. number=32'h1000_0022 while on src 1. One switch_pulse per step.
2. Skip invalid: src_valid=4'b1010 -> cur_src alternates 1,3,1. Then src_valid=4'b0000 -> IDLE within 10 cycles, number=0.
3. Stale: on src 2 with value 16'h0ABC, drop src_valid[2] -> number stays 32'h2000_0ABC and dots=8'h80. Restore valid -> dots=0 next cycle.
4. Manual: auto_en=0, manual_sel=3 (src 3 invalid) -> cur_src=3 one cycle later. No further switches for 100 cycles. dots[7]=1.
5. Hold: assert hold at timer=5 on src 0 for 20 cycles while changing manual_sel and values -> outputs frozen. After release, switch to src 1 happens 5 cycles later.
6. Async reset: pull reset_n low mid-dwell, between clock edges -> all outputs return to reset values immediately. After release, src_valid=4'b0100 -> cur_src=2 after one edge, with switch_pulse.
